// File: rtl/microtrace_checker.sv
// microtrace_checker: per-opcode programmable uPC sequence checker with first-error capture and saturating counts.
// Define MTRACE_FATAL_EN to stop simulation with $fatal on every detected error.
module microtrace_checker #(
    parameter int UPC_W   = 12,
    parameter int OP_W    = 8,
    parameter int NUM_OPS = 4,
    parameter int DEPTH   = 8,
    parameter int CNT_W   = 16,
    localparam int SW = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1,
    localparam int IW = $clog2(DEPTH),
    localparam int LW = IW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [UPC_W-1:0] upc,
    input  logic             upc_valid,
    input  logic [OP_W-1:0]  ir_opcode,
    input  logic             ir_load,
    input  logic             cfg_we,
    input  logic             cfg_hdr,
    input  logic [SW-1:0]    cfg_slot,
    input  logic [IW-1:0]    cfg_idx,
    input  logic [UPC_W-1:0] cfg_upc,
    input  logic [OP_W-1:0]  cfg_opcode,
    input  logic [LW-1:0]    cfg_len,
    input  logic             cfg_en,
    output logic             cfg_ready,
    input  logic             clr,
    output logic             busy,
    output logic             err_pulse,
    output logic             err_sticky,
    output logic [1:0]       err_code,
    output logic [OP_W-1:0]  err_opcode,
    output logic [LW-1:0]    err_step,
    output logic [UPC_W-1:0] err_exp,
    output logic [UPC_W-1:0] err_act,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt
);
    typedef enum logic {IDLE, TRACK} state_t;
    state_t r_state, w_next;
    logic [NUM_OPS-1:0] r_en;
    logic [OP_W-1:0]    r_op   [NUM_OPS];
    logic [LW-1:0]      r_len  [NUM_OPS];
    logic [UPC_W-1:0]   r_step [NUM_OPS][DEPTH];
    logic [LW-1:0]      r_idx;
    logic [SW-1:0]      r_slot;
    logic               r_busy, r_cfg_ready, r_err_pulse, r_err_sticky;
    logic [1:0]         r_err_code;
    logic [OP_W-1:0]    r_err_opcode;
    logic [LW-1:0]      r_err_step;
    logic [UPC_W-1:0]   r_err_exp, r_err_act;
    logic [CNT_W-1:0]   r_pass, r_fail;
    logic               w_we, w_hit, w_trk, w_trunc, w_tmis, w_tpass;
    logic               w_new, w_nmis, w_npass, w_nstart, w_oerr, w_pinc;
    logic [SW-1:0]      w_hslot;
    logic [UPC_W-1:0]   w_texp, w_nexp;
    logic [1:0]         w_finc;
    logic [CNT_W:0]     w_psum, w_fsum;

    // Descending scan so the lowest matching slot is the one left standing
    always_comb begin
        w_hit = 1'b0;
        w_hslot = '0;
        for (int i = NUM_OPS - 1; i >= 0; i--)
            if (r_en[i] && r_op[i] == ir_opcode) begin
                w_hit = 1'b1;
                w_hslot = SW'(i);
            end
    end

    assign w_we     = cfg_we && r_cfg_ready;
    assign w_trk    = r_state == TRACK && upc_valid;
    assign w_trunc  = w_trk && ir_load;
    assign w_texp   = r_step[r_slot][r_idx[IW-1:0]];
    assign w_tmis   = w_trk && !ir_load && upc != w_texp;
    assign w_tpass  = w_trk && !ir_load && upc == w_texp && r_idx == r_len[r_slot] - LW'(1);
    assign w_new    = ir_load && upc_valid && w_hit;
    assign w_nexp   = r_step[w_hslot][0];
    assign w_nmis   = w_new && upc != w_nexp;
    assign w_npass  = w_new && upc == w_nexp && r_len[w_hslot] == LW'(1);
    assign w_nstart = w_new && upc == w_nexp && r_len[w_hslot] != LW'(1);
    assign w_oerr   = w_tmis || w_trunc;
    assign w_finc   = {1'b0, w_oerr} + {1'b0, w_nmis};
    assign w_pinc   = w_tpass || w_npass;
    assign w_psum   = {1'b0, r_pass} + (CNT_W + 1)'(w_pinc);
    assign w_fsum   = {1'b0, r_fail} + (CNT_W + 1)'(w_finc);
    assign w_next   = w_nstart ? TRACK : (w_trk && (ir_load || w_tmis || w_tpass)) ? IDLE : r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en <= '0;
            for (int i = 0; i < NUM_OPS; i++) begin
                r_op[i]  <= '0;
                r_len[i] <= '0;
            end
        end else if (w_we && cfg_hdr) begin
            r_en[cfg_slot]  <= cfg_en;
            r_op[cfg_slot]  <= cfg_opcode;
            r_len[cfg_slot] <= cfg_len;
        end
    end

    // Step contents carry no reset; they are only meaningful once written
    always_ff @(posedge clk)
        if (w_we && !cfg_hdr)
            r_step[cfg_slot][cfg_idx] <= cfg_upc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_slot      <= '0;
            r_busy      <= 1'b0;
            r_cfg_ready <= 1'b1;
        end else begin
            r_state     <= w_next;
            r_busy      <= w_next == TRACK;
            r_cfg_ready <= w_next == IDLE;
            if (w_nstart) begin
                r_idx  <= LW'(1);
                r_slot <= w_hslot;
            end else if (w_trk) begin
                r_idx <= r_idx + LW'(1);
            end
        end
    end

    // An old-sequence error outranks a same-cycle step-0 error for capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_pulse  <= 1'b0;
            r_err_sticky <= 1'b0;
            r_err_code   <= '0;
            r_err_opcode <= '0;
            r_err_step   <= '0;
            r_err_exp    <= '0;
            r_err_act    <= '0;
            r_pass       <= '0;
            r_fail       <= '0;
        end else begin
            r_err_pulse <= w_oerr || w_nmis;
            if (clr) begin
                r_err_sticky <= 1'b0;
                r_err_code   <= '0;
                r_err_opcode <= '0;
                r_err_step   <= '0;
                r_err_exp    <= '0;
                r_err_act    <= '0;
                r_pass       <= '0;
                r_fail       <= '0;
            end else begin
                r_pass <= w_psum[CNT_W] ? '1 : w_psum[CNT_W-1:0];
                r_fail <= w_fsum[CNT_W] ? '1 : w_fsum[CNT_W-1:0];
                if (!r_err_sticky && (w_oerr || w_nmis)) begin
                    r_err_sticky <= 1'b1;
                    r_err_code   <= w_trunc ? 2'b10 : 2'b01;
                    r_err_opcode <= w_oerr ? r_op[r_slot] : ir_opcode;
                    r_err_step   <= w_oerr ? r_idx : '0;
                    r_err_exp    <= w_oerr ? w_texp : w_nexp;
                    r_err_act    <= upc;
                end
            end
        end
    end

`ifdef MTRACE_FATAL_EN
    always @(posedge clk)
        if (rst_n && (w_oerr || w_nmis))
            $fatal(1, "microtrace_checker error t=%0t code=%b op=%h step=%0d exp=%h act=%h", $time,
                   w_trunc ? 2'b10 : 2'b01, w_oerr ? r_op[r_slot] : ir_opcode,
                   w_oerr ? r_idx : '0, w_oerr ? w_texp : w_nexp, upc);
`endif

    assign cfg_ready  = r_cfg_ready;
    assign busy       = r_busy;
    assign err_pulse  = r_err_pulse;
    assign err_sticky = r_err_sticky;
    assign err_code   = r_err_code;
    assign err_opcode = r_err_opcode;
    assign err_step   = r_err_step;
    assign err_exp    = r_err_exp;
    assign err_act    = r_err_act;
    assign pass_cnt   = r_pass;
    assign fail_cnt   = r_fail;
endmodule

// File: tb/tb_microtrace_checker.sv
// tb_microtrace_checker: directed stimulus, queue-based reference model checked every cycle, plus literal checkpoints.
module tb_microtrace_checker;
    localparam int UPC_W = 12, OP_W = 8, NUM_OPS = 4, DEPTH = 8, CNT_W = 4;
    localparam int SW = 2, IW = 3, LW = 4;
    localparam int MAXC = (1 << CNT_W) - 1;

    logic clk = 0, rst_n = 0;
    logic [UPC_W-1:0] upc = 0;
    logic upc_valid = 0, ir_load = 0, cfg_we = 0, cfg_hdr = 0, cfg_en = 0, clr = 0;
    logic [OP_W-1:0] ir_opcode = 0, cfg_opcode = 0;
    logic [SW-1:0] cfg_slot = 0;
    logic [IW-1:0] cfg_idx = 0;
    logic [UPC_W-1:0] cfg_upc = 0;
    logic [LW-1:0] cfg_len = 0;
    logic cfg_ready, busy, err_pulse, err_sticky;
    logic [1:0] err_code;
    logic [OP_W-1:0] err_opcode;
    logic [LW-1:0] err_step;
    logic [UPC_W-1:0] err_exp, err_act;
    logic [CNT_W-1:0] pass_cnt, fail_cnt;

    int n_vec = 0, n_bad = 0;

    microtrace_checker #(.UPC_W(UPC_W), .OP_W(OP_W), .NUM_OPS(NUM_OPS), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .upc(upc), .upc_valid(upc_valid), .ir_opcode(ir_opcode), .ir_load(ir_load),
        .cfg_we(cfg_we), .cfg_hdr(cfg_hdr), .cfg_slot(cfg_slot), .cfg_idx(cfg_idx), .cfg_upc(cfg_upc),
        .cfg_opcode(cfg_opcode), .cfg_len(cfg_len), .cfg_en(cfg_en), .cfg_ready(cfg_ready), .clr(clr),
        .busy(busy), .err_pulse(err_pulse), .err_sticky(err_sticky), .err_code(err_code),
        .err_opcode(err_opcode), .err_step(err_step), .err_exp(err_exp), .err_act(err_act),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt));

    always #5 clk = ~clk;

    // Reference model: a table plus a queue of the still-expected uPCs of the live sequence
    bit m_en [NUM_OPS];
    int m_op [NUM_OPS], m_len [NUM_OPS];
    int m_step [NUM_OPS][DEPTH];
    int m_q[$];
    int m_pos, m_aop;
    int e_pass, e_fail, e_code, e_op, e_step, e_exp, e_act;
    bit e_pulse, e_sticky, e_busy;

    task automatic model_step();
        int ne, np, c, o, s, x, a, hit;
        int q[$];
        bit was_busy;
        ne = 0; np = 0; c = 0; o = 0; s = 0; x = 0; a = 0; hit = -1;
        was_busy = m_q.size() > 0;
        if (upc_valid) begin
            if (was_busy) begin
                if (ir_load || int'(upc) != m_q[0]) begin
                    c = ir_load ? 2 : 1; o = m_aop; s = m_pos; x = m_q[0]; a = int'(upc); ne = 1;
                    m_q.delete();
                end else begin
                    void'(m_q.pop_front());
                    m_pos++;
                    if (m_q.size() == 0) np++;
                end
            end
            if (ir_load) begin
                for (int i = 0; i < NUM_OPS; i++)
                    if (hit < 0 && m_en[i] && m_op[i] == int'(ir_opcode)) hit = i;
                if (hit >= 0) begin
                    for (int k = 0; k < m_len[hit]; k++) q.push_back(m_step[hit][k]);
                    if (int'(upc) != q[0]) begin
                        if (ne == 0) begin c = 1; o = int'(ir_opcode); s = 0; x = q[0]; a = int'(upc); end
                        ne++;
                    end else begin
                        void'(q.pop_front());
                        if (q.size() == 0) np++;
                        else begin m_q = q; m_pos = 1; m_aop = int'(ir_opcode); end
                    end
                end
            end
        end
        if (cfg_we && !was_busy) begin
            if (cfg_hdr) begin
                m_en[cfg_slot] = cfg_en; m_op[cfg_slot] = int'(cfg_opcode); m_len[cfg_slot] = int'(cfg_len);
            end else m_step[cfg_slot][cfg_idx] = int'(cfg_upc);
        end
        e_pulse = ne > 0;
        if (clr) begin
            e_pass = 0; e_fail = 0; e_sticky = 0;
            e_code = 0; e_op = 0; e_step = 0; e_exp = 0; e_act = 0;
        end else begin
            e_pass = (e_pass + np > MAXC) ? MAXC : e_pass + np;
            e_fail = (e_fail + ne > MAXC) ? MAXC : e_fail + ne;
            if (!e_sticky && ne > 0) begin
                e_sticky = 1; e_code = c; e_op = o; e_step = s; e_exp = x; e_act = a;
            end
        end
        e_busy = m_q.size() > 0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_OPS; i++) m_en[i] = 0;
            m_q.delete();
            m_pos = 0; m_aop = 0;
            e_pass = 0; e_fail = 0; e_code = 0; e_op = 0; e_step = 0; e_exp = 0; e_act = 0;
            e_pulse = 0; e_sticky = 0; e_busy = 0;
        end else model_step();
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            cmp("busy", 32'(busy), 32'(e_busy));
            cmp("cfg_ready", 32'(cfg_ready), 32'(!e_busy));
            cmp("err_pulse", 32'(err_pulse), 32'(e_pulse));
            cmp("err_sticky", 32'(err_sticky), 32'(e_sticky));
            cmp("err_code", 32'(err_code), e_code);
            cmp("err_opcode", 32'(err_opcode), e_op);
            cmp("err_step", 32'(err_step), e_step);
            cmp("err_exp", 32'(err_exp), e_exp);
            cmp("err_act", 32'(err_act), e_act);
            cmp("pass_cnt", 32'(pass_cnt), e_pass);
            cmp("fail_cnt", 32'(fail_cnt), e_fail);
        end
    end

    task automatic cyc(input bit v, input int u, input bit l, input int op, input bit c);
        @(negedge clk);
        upc_valid = v; upc = UPC_W'(u); ir_load = l; ir_opcode = OP_W'(op); clr = c; cfg_we = 0;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0);
    endtask

    task automatic wr(input bit hdr, input int slot, input int idx, input int u, input int op, input int len, input bit en);
        @(negedge clk);
        upc_valid = 0; ir_load = 0; clr = 0; cfg_we = 1; cfg_hdr = hdr;
        cfg_slot = SW'(slot); cfg_idx = IW'(idx); cfg_upc = UPC_W'(u);
        cfg_opcode = OP_W'(op); cfg_len = LW'(len); cfg_en = en;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1;
        idle();
        cmp("rst_busy", 32'(busy), 0);
        cmp("rst_ready", 32'(cfg_ready), 1);
        cmp("rst_pass", 32'(pass_cnt), 0);
        cmp("rst_code", 32'(err_code), 0);
        // NOP trace
        wr(1, 0, 0, 0, 8'h00, 3, 1);
        wr(0, 0, 0, 12'h000, 0, 0, 0);
        wr(0, 0, 1, 12'h001, 0, 0, 0);
        wr(0, 0, 2, 12'h000, 0, 0, 0);
        cyc(1, 12'h000, 1, 8'h00, 0);
        cyc(1, 12'h001, 0, 0, 0);
        cmp("nop_busy", 32'(busy), 1);
        cmp("nop_ready", 32'(cfg_ready), 0);
        cyc(1, 12'h000, 0, 0, 0);
        idle();
        cmp("nop_pass", 32'(pass_cnt), 1);
        cmp("nop_sticky", 32'(err_sticky), 0);
        // Mismatch at step 1
        cyc(1, 12'h000, 1, 8'h00, 0);
        cyc(1, 12'h002, 0, 0, 0);
        idle();
        cmp("mis_pulse", 32'(err_pulse), 1);
        cmp("mis_code", 32'(err_code), 1);
        cmp("mis_step", 32'(err_step), 1);
        cmp("mis_exp", 32'(err_exp), 12'h001);
        cmp("mis_act", 32'(err_act), 12'h002);
        cmp("mis_fail", 32'(fail_cnt), 1);
        idle();
        cmp("mis_pulse_off", 32'(err_pulse), 0);
        cyc(0, 0, 0, 0, 1);
        idle();
        cmp("clr_pass", 32'(pass_cnt), 0);
        cmp("clr_sticky", 32'(err_sticky), 0);
        // Stall between steps 0 and 1; a dispatch with upc_valid low is ignored
        cyc(1, 12'h000, 1, 8'h00, 0);
        repeat (5) cyc(0, 12'h3ff, 1, 8'h00, 0);
        cmp("stall_busy", 32'(busy), 1);
        cyc(1, 12'h001, 0, 0, 0);
        cyc(1, 12'h000, 0, 0, 0);
        idle();
        cmp("stall_pass", 32'(pass_cnt), 1);
        cmp("stall_sticky", 32'(err_sticky), 0);
        cyc(0, 0, 0, 0, 1);
        // Truncation at step 2, new sequence continues and completes
        cyc(1, 12'h000, 1, 8'h00, 0);
        cyc(1, 12'h001, 0, 0, 0);
        cyc(1, 12'h000, 1, 8'h00, 0);
        cyc(1, 12'h001, 0, 0, 0);
        cmp("trunc_code", 32'(err_code), 2);
        cmp("trunc_step", 32'(err_step), 2);
        cmp("trunc_busy", 32'(busy), 1);
        cyc(1, 12'h000, 0, 0, 0);
        idle();
        cmp("trunc_pass", 32'(pass_cnt), 1);
        cmp("trunc_fail", 32'(fail_cnt), 1);
        cyc(0, 0, 0, 0, 1);
        // Duplicate opcode in slots 1 and 3, plus a two-step slot 2
        wr(1, 1, 0, 0, 8'h20, 1, 1);
        wr(0, 1, 0, 12'h100, 0, 0, 0);
        wr(1, 3, 0, 0, 8'h20, 1, 1);
        wr(0, 3, 0, 12'h200, 0, 0, 0);
        wr(1, 2, 0, 0, 8'h10, 2, 1);
        wr(0, 2, 0, 12'h020, 0, 0, 0);
        wr(0, 2, 1, 12'h021, 0, 0, 0);
        cyc(1, 12'h100, 1, 8'h20, 0);
        idle();
        cmp("dup_pass", 32'(pass_cnt), 1);
        cyc(1, 12'h200, 1, 8'h20, 0);
        idle();
        cmp("dup_code", 32'(err_code), 1);
        cmp("dup_op", 32'(err_opcode), 8'h20);
        cmp("dup_step", 32'(err_step), 0);
        cmp("dup_exp", 32'(err_exp), 12'h100);
        cmp("dup_act", 32'(err_act), 12'h200);
        cyc(0, 0, 0, 0, 1);
        // Writes while busy are dropped
        cyc(1, 12'h000, 1, 8'h00, 0);
        wr(1, 1, 0, 0, 8'h20, 1, 0);
        wr(0, 1, 0, 12'h300, 0, 0, 0);
        cyc(1, 12'h001, 0, 0, 0);
        cyc(1, 12'h000, 0, 0, 0);
        cyc(1, 12'h100, 1, 8'h20, 0);
        idle();
        cmp("drop_pass", 32'(pass_cnt), 2);
        cmp("drop_sticky", 32'(err_sticky), 0);
        // Untracked opcode
        cyc(1, 12'h007, 1, 8'h55, 0);
        idle();
        cmp("untr_pass", 32'(pass_cnt), 2);
        cmp("untr_busy", 32'(busy), 0);
        // Truncation and new step-0 mismatch together
        cyc(1, 12'h000, 1, 8'h00, 0);
        cyc(1, 12'h099, 1, 8'h10, 0);
        idle();
        cmp("dbl_fail", 32'(fail_cnt), 2);
        cmp("dbl_code", 32'(err_code), 2);
        cmp("dbl_step", 32'(err_step), 1);
        cmp("dbl_exp", 32'(err_exp), 12'h001);
        cmp("dbl_act", 32'(err_act), 12'h099);
        cyc(0, 0, 0, 0, 1);
        // Back-to-back dispatches
        cyc(1, 12'h020, 1, 8'h10, 0);
        cyc(1, 12'h021, 0, 0, 0);
        cyc(1, 12'h100, 1, 8'h20, 0);
        cyc(1, 12'h100, 1, 8'h20, 0);
        idle();
        cmp("b2b_pass", 32'(pass_cnt), 3);
        cmp("b2b_fail", 32'(fail_cnt), 0);
        // Saturation, then clr together with a pass
        repeat (17) cyc(1, 12'h100, 1, 8'h20, 0);
        idle();
        cmp("sat_pass", 32'(pass_cnt), 15);
        cyc(1, 12'h222, 1, 8'h20, 0);
        cyc(1, 12'h100, 1, 8'h20, 1);
        idle();
        cmp("clrp_pass", 32'(pass_cnt), 0);
        cmp("clrp_sticky", 32'(err_sticky), 0);
        // Reset mid-sequence
        cyc(1, 12'h000, 1, 8'h00, 0);
        cyc(1, 12'h001, 0, 0, 0);
        @(negedge clk);
        upc_valid = 0; ir_load = 0;
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        idle();
        cmp("rmid_busy", 32'(busy), 0);
        cmp("rmid_fail", 32'(fail_cnt), 0);
        cyc(1, 12'h000, 1, 8'h00, 0);
        idle();
        cmp("rmid_untracked", 32'(busy), 0);
        idle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/microtrace_checker.md
# microtrace_checker

Parametrised microsequencer trace checker for ZAKS32 simulation and on-chip debug. Holds up to NUM_OPS programmable expected uPC sequences, one per tracked opcode, each up to DEPTH steps. On every instruction dispatch it walks the matching sequence step by step against the live uPC. It reports the first divergence with full context, keeps saturating pass/fail counts, and detects sequences cut short by the next dispatch.

## Interface
- UPC_W, 12, micro-PC width
- OP_W, 8, opcode width
- NUM_OPS, 4, number of sequence slots (1..16)
- DEPTH, 8, max steps per sequence (2..64)
- CNT_W, 16, pass/fail counter width

- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- upc  in  UPC_W  current micro-PC
- upc_valid  in  1  upc advanced this cycle; low = stall, no step consumed
- ir_opcode  in  OP_W  opcode of dispatching instruction
- ir_load  in  1  dispatch strobe; qualifies ir_opcode; this cycle's upc is step 0
- cfg_we  in  1  table write strobe
- cfg_hdr  in  1  1 = header write (opcode/len/enable), 0 = step write
- cfg_slot  in  $clog2(NUM_OPS)  slot index
- cfg_idx  in  $clog2(DEPTH)  step index (step write)
- cfg_upc  in  UPC_W  expected uPC (step write)
- cfg_opcode  in  OP_W  tracked opcode (header write)
- cfg_len  in  $clog2(DEPTH)+1  sequence length 1..DEPTH (header write)
- cfg_en  in  1  slot enable (header write)
- cfg_ready  out  1  high when writes are accepted (state IDLE)
- clr  in  1  sync clear of counters, sticky error, capture registers
- busy  out  1  state TRACK
- err_pulse  out  1  one-cycle error strobe
- err_sticky  out  1  set on first error, held until clr
- err_code  out  2  01 mismatch, 10 truncated (captured on first error)
- err_opcode  out  OP_W  opcode of first error
- err_step  out  $clog2(DEPTH)+1  step index of first error
- err_exp  out  UPC_W  expected uPC of first error (truncated: next expected)
- err_act  out  UPC_W  actual uPC of first error (truncated: upc at new dispatch)
- pass_cnt  out  CNT_W  completed matching sequences, saturating
- fail_cnt  out  CNT_W  errored sequences, saturating

## Operation
- Table: per slot {en, opcode, len, step[DEPTH]}. Reset clears en for all slots. Step contents are undefined after reset.
- Writes apply only when cfg_we && cfg_ready. Writes with cfg_ready low are silently dropped. A write to the same cycle's lookup slot is seen from the next cycle.
- Lookup on ir_load && upc_valid: the lowest-index enabled slot with opcode == ir_opcode wins. No hit means the instruction is untracked; no count, no error.
- FSM IDLE: on a hit, compare upc against step[0].
  - Mismatch: error, stay IDLE.
  - Match with len==1: pass, stay IDLE.
  - Match with len>1: go to TRACK with idx=1 and the slot latched.
- FSM TRACK: each upc_valid cycle compares upc against step[idx].
  - Mismatch: error (code 01), go to IDLE.
  - Match with idx==len-1: pass, go to IDLE.
  - Otherwise idx++.
- ir_load in TRACK (premature dispatch): truncation error (code 10) for the old sequence. In the same cycle, the new dispatch runs the IDLE lookup/step-0 logic. If both sequences fail, fail_cnt increments by 2 and the capture keeps the truncation.
- ir_load with upc_valid low is ignored.
- Capture registers load only when err_sticky is 0, so first error wins.
- Counters saturate at all-ones.
- clr has priority over same-cycle increments and capture. FSM state is unaffected by clr.

## Timing
- All outputs registered. err_pulse, counters, and capture update the cycle after the sampled upc.
- busy and cfg_ready change the cycle after the transition-causing sample.
- Reset values:
  - busy=0, cfg_ready=1
  - err_pulse=0, err_sticky=0, err_code=0
  - err_opcode, err_step, err_exp, err_act = 0
  - pass_cnt=0, fail_cnt=0
  - state IDLE
- Reset mid-sequence aborts without error or count.
- Throughput: one step per upc_valid cycle, back-to-back dispatches supported.
- Stalls (upc_valid=0) hold idx indefinitely.

## Configuration
- MTRACE_FATAL_EN defined: on every err_pulse, the simulation calls $fatal(1, ...) printing time, err_code, opcode, step, expected, and actual.
- MTRACE_FATAL_EN undefined: no non-synthesisable code. Errors are reported only through the ports.

## Test plan
- NOP trace: slot0 = {op 0x00, len 3, 0x000, 0x001, 0x000}. ir_load op 0x00 with upc 0x000, 0x001, 0x000 -> pass_cnt=1, err_sticky=0.
- Mismatch: same slot, upc 0x000, 0x002 -> err_pulse one cycle later, err_code=01, err_step=1, err_exp=0x001, err_act=0x002, fail_cnt=1.
- Stall: upc_valid low for 5 cycles between steps 0 and 1, then 0x001, 0x000 -> pass, busy high throughout.
- Truncation: ir_load op 0x00 again at step 2 with upc 0x000 -> err_code=10, err_step=2. The new sequence proceeds to TRACK with busy staying 1, and completes -> pass_cnt=1, fail_cnt=1.
- Duplicate opcode in slots 1 and 3 -> slot 1 is used. A cfg_we while busy is dropped, with table readback behaviour unchanged.
- Saturation and clr: CNT_W=4, 17 passes -> pass_cnt=15. clr together with a pass -> pass_cnt=0, err_sticky=0.
